apb_reg_bank: RTL
=================

// Module: apb_reg_bank
// PURPOSE
//  Parametrised APB3/APB4 slave register bank. Single-clock successor of the fixed data/config/status slave.
//  Provides DATA_REG_NUM byte-strobed data registers, a config register and a W1C sticky status register.
//  Adds a programmable wait-state handshake (pready) and pslverr for unmapped addresses.
//  Sits between the APB interconnect and core logic on the same pclk domain.
// PARAMETERS
//  ADDR_WIDTH        10     APB address width (word address, as decoded)
//  DATA_REG_NUM      4      number of 32-bit data registers, 1..16
//  DATA_REG_ADDR     10'd8  address of data reg 0; reg k at DATA_REG_ADDR+k
//  CONFIG_REG_ADDR   10'd6  config register address
//  STATUS_REG_ADDR   10'd7  status register address
//  CONFIG_REG_WIDTH  8      config width, 1..32
//  STATUS_REG_WIDTH  8      status width, 1..32
//  WAIT_STATES       1      access cycles with pready=0 before completion, 0..15
// PORTS
//  pclk       in   1                  clock
//  preset_n   in   1                  async active-low reset
//  paddr      in   ADDR_WIDTH         APB address
//  psel       in   1                  slave select
//  penable    in   1                  access phase
//  pwrite     in   1                  1=write 0=read
//  pwdata     in   32                 write data
//  pstrb      in   4                  byte strobes (writes only)
//  pready     out  1                  transfer complete
//  prdata     out  32                 read data, valid when pready=1
//  pslverr    out  1                  error, valid when pready=1
//  config_o   out  CONFIG_REG_WIDTH   config register contents
//  status_i   in   STATUS_REG_WIDTH   per-bit set pulses into sticky status
//  data_o     out  DATA_REG_NUM*32    data regs, reg k at [32k+31:32k]
//  data_wr_o  out  DATA_REG_NUM       1-cycle pulse after a committed write to reg k
// BEHAVIOUR
//  - Single clock pclk; reset asynchronous, active-low (preset_n). Reset: pready=0, pslverr=0, prdata=0,
//    all registers 0, data_wr_o=0, FSM=IDLE, wait counter=0.
//  - FSM IDLE->WAIT->DONE->IDLE. IDLE: psel&!penable (setup) latches addr/dir, cnt<=WAIT_STATES, ->WAIT.
//    WAIT: cnt==0 -> set pready=1, prdata, pslverr (registered), ->DONE; else cnt--.
//    DONE: pready=1 for exactly this cycle; write commits at its closing edge; ->IDLE.
//  - Timing: setup T0, access T1..T(1+W), pready=1 in T(1+W); write visible on outputs T(2+W); 2+W cycles total.
//  - Back-to-back: setup seen in DONE cycle is not accepted (APB requires IDLE/setup); next setup taken in IDLE.
//  - psel deasserted in WAIT/DONE: abort, ->IDLE, no write, pready=0. penable=1 in IDLE without setup: ignored.
//  - Decode: valid = config | status | DATA_REG_ADDR<=paddr<DATA_REG_ADDR+DATA_REG_NUM (all compare full width).
//    Invalid: pslverr=1, prdata=0, no state change. pready still follows wait states.
//  - Writes: byte lane b updated only when pstrb[b]; pstrb=0 -> no change, no error, no data_wr_o pulse.
//    Config: lanes beyond CONFIG_REG_WIDTH ignored. Status: W1C per bit under strobes.
//  - Status sticky: bit set when status_i bit=1 any cycle; same-cycle set and W1C clear -> set wins.
//  - Reads: unused upper bits zero-extended. Status read returns sticky value, not status_i.
//  - Reset mid-transfer: immediate abort to reset values; no partial write.
// CONFIGURATION
//  APB_REG_ERR_CNT_EN defined: 8-bit error counter at ERR_CNT_ADDR (package constant 10'd4), increments on each
//    pslverr completion, saturates at 8'hFF; any write with pstrb[0]=1 clears it (write wins over same-cycle inc).
//  Not defined: no counter; address 10'd4 decodes as invalid -> pslverr=1.
// STRUCTURE
//  Package apb_reg_pkg: state_t enum {IDLE,WAIT,DONE}, ERR_CNT_ADDR, function byte_merge(old,new,strb).
//  Sub-module apb_status_w1c (WIDTH param): sticky set/W1C-clear register with set-priority.
// TESTING
//  1 W=0: write 32'hA5A5_1234 strb 4'hF to 10'd8 -> pready 1 in T1, data_o[31:0]=A5A51234, data_wr_o[0] pulse.
//  2 W=3: read 10'd6 after config write 8'h5C -> pready low T1..T3, high T4, prdata=32'h0000_005C.
//  3 Write 32'hFFFF_FFFF strb 4'b0101 to 10'd9 over 0 -> reg1=32'h00FF_00FF; pstrb=0 write -> no change/pulse.
//  4 status_i[2] pulse -> read 10'd7 =32'h4; W1C 32'h4 with same-cycle status_i[2]=1 -> bit stays 1.
//  5 Read 10'd3 -> pslverr=1, prdata=0; with APB_REG_ERR_CNT_EN read 10'd4 -> 32'h1.
//  6 preset_n low during WAIT of write -> all outputs 0, target register unchanged after release.

Source files
------------

// File: rtl/apb_reg_pkg.sv
// apb_reg_pkg: shared FSM type, error-counter address and byte-lane merge helper.
// ERR_CNT_ADDR is only decoded when APB_REG_ERR_CNT_EN is defined.
package apb_reg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [9:0] ERR_CNT_ADDR = 10'd4;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/apb_reg_bank_if.sv
// apb_reg_bank_if: APB3/APB4 bus bundle between interconnect and register bank.
// master drives the request side, slave drives pready/prdata/pslverr.
interface apb_reg_bank_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [31:0]           pwdata;
    logic [3:0]            pstrb;
    logic                  pready;
    logic [31:0]           prdata;
    logic                  pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_status_w1c.sv
// apb_status_w1c: sticky status bits, set by pulses and cleared by W1C writes.
// A set pulse in the same cycle as a clear keeps the bit set.
module apb_status_w1c
    import apb_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic [WIDTH-1:0] set_bits,
    input  logic [WIDTH-1:0] clr_bits,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            q <= '0;
        end else begin
            q <= (q & ~clr_bits) | set_bits;
        end
    end

endmodule

// File: rtl/apb_reg_bank.sv
// apb_reg_bank: APB slave with byte-strobed data regs, config reg and W1C status.
// Define APB_REG_ERR_CNT_EN to add a saturating pslverr counter at ERR_CNT_ADDR.
module apb_reg_bank
    import apb_reg_pkg::*;
#(
    parameter int                    ADDR_WIDTH       = 10,
    parameter int                    DATA_REG_NUM     = 4,
    parameter logic [ADDR_WIDTH-1:0] DATA_REG_ADDR    = ADDR_WIDTH'(8),
    parameter logic [ADDR_WIDTH-1:0] CONFIG_REG_ADDR  = ADDR_WIDTH'(6),
    parameter logic [ADDR_WIDTH-1:0] STATUS_REG_ADDR  = ADDR_WIDTH'(7),
    parameter int                    CONFIG_REG_WIDTH = 8,
    parameter int                    STATUS_REG_WIDTH = 8,
    parameter int                    WAIT_STATES      = 1
) (
    input  logic                          pclk,
    input  logic                          preset_n,
    apb_reg_bank_if.slave                 apb,
    output logic [CONFIG_REG_WIDTH-1:0]   config_o,
    input  logic [STATUS_REG_WIDTH-1:0]   status_i,
    output logic [DATA_REG_NUM*32-1:0]    data_o,
    output logic [DATA_REG_NUM-1:0]       data_wr_o
);

    localparam logic [3:0] CNT_INIT =
        (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    wr_q;
    logic                    pready_q;
    logic [31:0]             prdata_q;
    logic                    pslverr_q;

    logic [31:0]             data_q [DATA_REG_NUM];
    logic [DATA_REG_NUM-1:0] data_wr_q;
    logic [CONFIG_REG_WIDTH-1:0] cfg_q;
    logic [STATUS_REG_WIDTH-1:0] st_q;
    logic [STATUS_REG_WIDTH-1:0] st_clr;

    logic                    setup;
    logic                    finish;
    logic                    commit;
    logic                    commit_wr;
    logic [ADDR_WIDTH-1:0]   dec_addr;
    logic                    dec_wr;
    logic                    cfg_hit;
    logic                    st_hit;
    logic                    err_hit;
    logic                    hit_any;
    logic [DATA_REG_NUM-1:0] data_hit;
    logic [31:0]             rd_data;
    logic [31:0]             strb_mask;
    logic [7:0]              err_rd;

    assign setup = apb.psel & ~apb.penable;

    // In IDLE the live bus is decoded so a zero-wait transfer completes
    // straight out of the setup cycle; afterwards the latched request is used.
    assign dec_addr = (state_q == IDLE) ? apb.paddr : addr_q;
    assign dec_wr   = (state_q == IDLE) ? apb.pwrite : wr_q;

    assign commit    = (state_q == DONE) & apb.psel;
    assign commit_wr = commit & wr_q;

    always_comb begin
        finish = 1'b0;
        case (state_q)
            IDLE:    finish = setup && (WAIT_STATES == 0);
            WAIT:    finish = apb.psel && (cnt_q == 4'd0);
            default: finish = 1'b0;
        endcase
    end

    always_comb begin
        data_hit = '0;
        for (int k = 0; k < DATA_REG_NUM; k++) begin
            data_hit[k] = (dec_addr == DATA_REG_ADDR + ADDR_WIDTH'(k));
        end
    end

    assign cfg_hit = (dec_addr == CONFIG_REG_ADDR);
    assign st_hit  = (dec_addr == STATUS_REG_ADDR);
    assign hit_any = cfg_hit | st_hit | err_hit | (|data_hit);

    always_comb begin
        rd_data = '0;
        if (cfg_hit) rd_data = 32'(cfg_q);
        if (st_hit)  rd_data = 32'(st_q);
        if (err_hit) rd_data = 32'(err_rd);
        for (int k = 0; k < DATA_REG_NUM; k++) begin
            if (data_hit[k]) rd_data = data_q[k];
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            pready_q  <= finish;
            prdata_q  <= (finish && hit_any && !dec_wr) ? rd_data : '0;
            pslverr_q <= finish && !hit_any;
            case (state_q)
                IDLE: begin
                    if (setup) begin
                        addr_q  <= apb.paddr;
                        wr_q    <= apb.pwrite;
                        cnt_q   <= CNT_INIT;
                        state_q <= (WAIT_STATES == 0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (!apb.psel) begin
                        state_q <= IDLE;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int k = 0; k < DATA_REG_NUM; k++) begin
                data_q[k] <= '0;
            end
            data_wr_q <= '0;
            cfg_q     <= '0;
        end else begin
            for (int k = 0; k < DATA_REG_NUM; k++) begin
                data_wr_q[k] <= commit_wr && data_hit[k] && (|apb.pstrb);
                if (commit_wr && data_hit[k]) begin
                    data_q[k] <= byte_merge(data_q[k], apb.pwdata, apb.pstrb);
                end
            end
            if (commit_wr && cfg_hit) begin
                cfg_q <= CONFIG_REG_WIDTH'(
                    byte_merge(32'(cfg_q), apb.pwdata, apb.pstrb));
            end
        end
    end

    assign strb_mask = {{8{apb.pstrb[3]}}, {8{apb.pstrb[2]}},
                        {8{apb.pstrb[1]}}, {8{apb.pstrb[0]}}};

    assign st_clr = (commit_wr && st_hit)
                  ? STATUS_REG_WIDTH'(apb.pwdata & strb_mask)
                  : '0;

    apb_status_w1c #(
        .WIDTH (STATUS_REG_WIDTH)
    ) u_status (
        .pclk     (pclk),
        .preset_n (preset_n),
        .set_bits (status_i),
        .clr_bits (st_clr),
        .q        (st_q)
    );

`ifdef APB_REG_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    assign err_hit = (dec_addr == ADDR_WIDTH'(ERR_CNT_ADDR));
    assign err_rd  = err_cnt_q;

    // A clearing write beats an increment landing in the same cycle.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            err_cnt_q <= 8'd0;
        end else if (commit_wr && err_hit && apb.pstrb[0]) begin
            err_cnt_q <= 8'd0;
        end else if (commit && pslverr_q && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end
`else
    assign err_hit = 1'b0;
    assign err_rd  = 8'd0;
`endif

    for (genvar k = 0; k < DATA_REG_NUM; k++) begin : g_data
        assign data_o[32*k +: 32] = data_q[k];
    end

    assign data_wr_o   = data_wr_q;
    assign config_o    = cfg_q;
    assign apb.pready  = pready_q;
    assign apb.prdata  = prdata_q;
    assign apb.pslverr = pslverr_q;

endmodule
